instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Parametrised multi-cycle control sequencer for the RV32I core; replaces the fixed free-running stage counter.
//  Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and skips MEMORY for non-load/store opcodes.
//  Waits on a memory req/ack handshake, honours a stall input and counts retired instructions.
//  Drives instruction-register, PC and register-file write enables for the datapath.
// PARAMETERS
//  CNT_W          64  width of retired-instruction counter
//  TIMEOUT_CYCLES 255 max wait cycles for mem_ack (used only with SEQ_MEM_TIMEOUT_EN); must be >=1
//  TMO_W          8   width of timeout counter; 2**TMO_W > TIMEOUT_CYCLES
// PORTS
//  clk      in  1      clock, rising edge
//  rst      in  1      asynchronous, active-low reset
//  run      in  1      level; 1 = execute, 0 = stop at next instruction boundary
//  stall    in  1      hold current stage (DECODE/EXECUTE/WRITEBACK only)
//  opcode   in  7      opcode of current instruction register
//  mem_req  out 1      memory access request
//  mem_we   out 1      memory write strobe, qualified by mem_req
//  mem_ack  in  1      memory completes access this cycle
//  ir_en    out 1      load instruction register
//  pc_en    out 1      update PC
//  rf_we    out 1      register-file write enable
//  stage    out 3      encoded state: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 FAULT=6
//  busy     out 1      state != IDLE
//  retired  out CNT_W  retired-instruction count
//  fault    out 1      sticky memory-timeout fault
// BEHAVIOUR
//  Reset (rst=0, async, any state): state=IDLE, retired=0, timeout cnt=0; all outputs 0. Reset mid-access drops mem_req immediately.
//  IDLE: -> FETCH when run=1.
//  FETCH: mem_req=1, mem_we=0; stays until mem_ack; ir_en = mem_ack (same cycle); then -> DECODE.
//  DECODE: -> EXECUTE.
//  EXECUTE: -> MEMORY if opcode==7'b0000011 (LOAD) or 7'b0100011 (STORE), else -> WRITEBACK.
//  MEMORY: mem_req=1, mem_we=(opcode==STORE); stays until mem_ack; then -> WRITEBACK.
//  WRITEBACK: pc_en=1; rf_we=1 unless opcode is STORE or BRANCH (7'b1100011); retired+=1.
//   Next state: FETCH if run=1, else IDLE.
//  stall=1 in DECODE/EXECUTE/WRITEBACK: state held; pc_en=rf_we=0; retired not incremented.
//  stall is ignored in IDLE/FETCH/MEMORY. mem_ack is ignored outside FETCH/MEMORY.
//  run=0 mid-instruction does not abort; the instruction completes through WRITEBACK, then IDLE.
//  Latency: mem_ack on the first request cycle -> 4 cycles for ALU/branch/jump and 5 cycles for load/store; each wait cycle adds 1.
//  retired wraps 2**CNT_W-1 -> 0 without a flag.
//  Outputs are decoded from state; ir_en is the only output that depends combinationally on mem_ack.
//  opcode is sampled only in EXECUTE, MEMORY and WRITEBACK; it is stable after FETCH.
// CONFIGURATION
//  SEQ_MEM_TIMEOUT_EN defined:
//   - Wait counter increments on each FETCH/MEMORY cycle without mem_ack and clears on ack or state change.
//   - When the count reaches TIMEOUT_CYCLES without ack: -> FAULT. In FAULT, fault=1 and all enables and mem_req are 0.
//   - FAULT exits only through reset. stage=6.
//  SEQ_MEM_TIMEOUT_EN undefined: no wait counter; FETCH/MEMORY wait indefinitely; fault tied 0; FAULT state unreachable.
// TESTING
//  T1 rst low 3 cycles then high, run=1, opcode=0010011 (ADDI), mem_ack=1 constant -> stage 1,2,3,5,1...;
//     ir_en in cycle 1, pc_en and rf_we in cycle 4; retired=1 after 4 cycles.
//  T2 LOAD (0000011), ack 3 cycles late in MEMORY -> mem_req=1, mem_we=0 for 4 MEMORY cycles;
//     rf_we=1 in WRITEBACK; total 8 cycles.
//  T3 STORE (0100011) -> mem_we=1 in MEMORY, rf_we=0 and pc_en=1 in WRITEBACK; BRANCH (1100011) -> rf_we=0.
//  T4 stall=1 for 2 cycles in EXECUTE, then run=0 in DECODE of the next instruction
//     -> EXECUTE lasts 3 cycles; the second instruction retires; then stage=0 and busy=0.
//  T5 CNT_W=4: 17 ADDI retired -> retired=1 (wrap via 0); assert rst during MEMORY -> mem_req=0 before the next edge, stage=0.
//  T6 SEQ_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ack=0 -> fault=1 and stage=6 after 8 FETCH cycles; it stays set until rst.
//     With the macro undefined -> FETCH held for 100 cycles and fault=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer for the RV32I core.
// Optional memory-ack watchdog is enabled by defining SEQ_MEM_TIMEOUT_EN.
module instr_sequencer #(
  parameter int CNT_W          = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             stall,
  input  logic [6:0]       opcode,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             ir_en,
  output logic             pc_en,
  output logic             rf_we,
  output logic [2:0]       stage,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Reject configurations whose wait counter could never reach the limit.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**TMO_W) begin : g_bad_cfg
    $error("instr_sequencer: TIMEOUT_CYCLES must be >= 1 and < 2**TMO_W");
  end

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       is_store;
  logic       is_mem_op;
  logic       no_rf_write;
  logic       mem_wait;
  logic       timeout_hit;
  logic       retire;

  assign is_store    = (opcode == OP_STORE);
  assign is_mem_op   = (opcode == OP_LOAD) || is_store;
  assign no_rf_write = is_store || (opcode == OP_BRANCH);
  assign mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEMORY)) && !mem_ack;
  assign retire      = (state_q == S_WRITEBACK) && !stall;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] wait_q;

  // The cycle holding TMO_LAST is the TIMEOUT_CYCLES-th unacknowledged cycle.
  assign timeout_hit = mem_wait && (wait_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else if (mem_wait && !timeout_hit) begin
      wait_q <= wait_q + 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  assign fault = (state_q == S_FAULT);
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack)          state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (!stall) state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (!stall) state_d = is_mem_op ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (mem_ack)          state_d = S_WRITEBACK;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_WRITEBACK: begin
        if (!stall) state_d = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + 1'b1;
    end
  end

  // Everything except ir_en and the stall gating is a pure decode of the state.
  assign stage   = state_q;
  assign busy    = (state_q != S_IDLE);
  assign mem_req = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign mem_we  = (state_q == S_MEMORY) && is_store;
  assign ir_en   = (state_q == S_FETCH) && mem_ack;
  assign pc_en   = retire;
  assign rf_we   = retire && !no_rf_write;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, ALU/load/store/branch flows, stall, run-stop,
// counter wrap, reset mid-access and the memory-ack wait / timeout behaviour.
module tb_instr_sequencer;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Observed vector: {stage[2:0], busy, mem_req, mem_we, ir_en, pc_en, rf_we, fault}
  localparam logic [9:0] O_IDLE    = 10'b000_0000000;
  localparam logic [9:0] O_F_ACK   = 10'b001_1101000;
  localparam logic [9:0] O_F_WAIT  = 10'b001_1100000;
  localparam logic [9:0] O_DEC     = 10'b010_1000000;
  localparam logic [9:0] O_EXE     = 10'b011_1000000;
  localparam logic [9:0] O_MEM_RD  = 10'b100_1100000;
  localparam logic [9:0] O_MEM_WR  = 10'b100_1110000;
  localparam logic [9:0] O_WB_RF   = 10'b101_1000110;
  localparam logic [9:0] O_WB_NORF = 10'b101_1000100;
  localparam logic [9:0] O_WB_HOLD = 10'b101_1000000;
  localparam logic [9:0] O_FAULT   = 10'b110_1000001;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             stall;
  logic [6:0]       opcode;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic             ir_en;
  logic             pc_en;
  logic             rf_we;
  logic [2:0]       stage;
  logic             busy;
  logic [CNT_W-1:0] retired;
  logic             fault;
  logic [9:0]       obs;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  assign obs = {stage, busy, mem_req, mem_we, ir_en, pc_en, rf_we, fault};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  instr_sequencer #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(8),
    .TMO_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .stall(stall),
    .opcode(opcode),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_ack(mem_ack),
    .ir_en(ir_en),
    .pc_en(pc_en),
    .rf_we(rf_we),
    .stage(stage),
    .busy(busy),
    .retired(retired),
    .fault(fault)
  );

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; run = 1'b1; stall = 1'b0; opcode = OP_ADDI; mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (obs !== O_IDLE) begin
      miss_cnt++; $display("FAIL reset_outputs obs=%b exp=%b", obs, O_IDLE);
    end
    vec_cnt++;
    if (retired !== 4'd0) begin
      miss_cnt++; $display("FAIL reset_retired obs=%0d exp=0", retired);
    end
  endtask

  task automatic test_alu();
    logic [9:0] exp_a [4] = '{O_F_ACK, O_DEC, O_EXE, O_WB_RF};
    logic [9:0] exp_b [3] = '{O_DEC, O_EXE, O_WB_RF};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== exp_a[i]) begin
        miss_cnt++; $display("FAIL alu_cycle%0d obs=%b exp=%b", i + 1, obs, exp_a[i]);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_F_ACK || retired !== 4'd1) begin
      miss_cnt++; $display("FAIL alu_refetch obs=%b/%0d exp=%b/1", obs, retired, O_F_ACK);
    end
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== exp_b[i]) begin
        miss_cnt++; $display("FAIL alu_drain%0d obs=%b exp=%b", i, obs, exp_b[i]);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_IDLE || retired !== 4'd2) begin
      miss_cnt++; $display("FAIL alu_stop obs=%b/%0d exp=%b/2", obs, retired, O_IDLE);
    end
  endtask

  task automatic test_load();
    opcode = OP_LOAD; run = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_F_ACK) begin
      miss_cnt++; $display("FAIL load_fetch obs=%b exp=%b", obs, O_F_ACK);
    end
    run = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_DEC) begin
      miss_cnt++; $display("FAIL load_decode obs=%b exp=%b", obs, O_DEC);
    end
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_EXE) begin
      miss_cnt++; $display("FAIL load_execute obs=%b exp=%b", obs, O_EXE);
    end
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== O_MEM_RD) begin
        miss_cnt++; $display("FAIL load_mem%0d obs=%b exp=%b", i, obs, O_MEM_RD);
      end
      if (i == 3) mem_ack = 1'b1;
    end
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_WB_RF) begin
      miss_cnt++; $display("FAIL load_wb obs=%b exp=%b", obs, O_WB_RF);
    end
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_IDLE || retired !== 4'd3) begin
      miss_cnt++; $display("FAIL load_done obs=%b/%0d exp=%b/3", obs, retired, O_IDLE);
    end
  endtask

  task automatic test_store_branch();
    logic [9:0] exp_s [6] = '{O_F_ACK, O_DEC, O_EXE, O_MEM_WR, O_WB_NORF, O_IDLE};
    logic [9:0] exp_b [5] = '{O_F_ACK, O_DEC, O_EXE, O_WB_NORF, O_IDLE};
    opcode = OP_STORE; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== exp_s[i]) begin
        miss_cnt++; $display("FAIL store_cycle%0d obs=%b exp=%b", i + 1, obs, exp_s[i]);
      end
      if (i == 0) run = 1'b0;
    end
    opcode = OP_BRANCH; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== exp_b[i]) begin
        miss_cnt++; $display("FAIL branch_cycle%0d obs=%b exp=%b", i + 1, obs, exp_b[i]);
      end
      if (i == 0) run = 1'b0;
    end
    vec_cnt++;
    if (retired !== 4'd5) begin
      miss_cnt++; $display("FAIL store_branch_retired obs=%0d exp=5", retired);
    end
  endtask

  task automatic test_stall_run();
    logic [9:0] exp_q [12] = '{O_F_ACK, O_DEC, O_EXE, O_EXE, O_EXE, O_WB_RF,
                               O_F_ACK, O_DEC, O_EXE, O_WB_HOLD, O_WB_RF, O_IDLE};
    opcode = OP_ADDI; run = 1'b1; stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        miss_cnt++; $display("FAIL stall_cycle%0d obs=%b exp=%b", i + 1, obs, exp_q[i]);
      end
      case (i)
        2: stall = 1'b1;
        4: stall = 1'b0;
        7: run = 1'b0;
        8: begin @(posedge clk); #1; stall = 1'b1; end
        9: begin
          vec_cnt++;
          if (retired !== 4'd6) begin
            miss_cnt++; $display("FAIL stall_wb_hold_retired obs=%0d exp=6", retired);
          end
          @(posedge clk); #1; stall = 1'b0;
        end
        default: ;
      endcase
    end
    vec_cnt++;
    if (retired !== 4'd7) begin
      miss_cnt++; $display("FAIL stall_run_retired obs=%0d exp=7", retired);
    end
  endtask

  task automatic test_wrap_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (retired !== 4'd0 || obs !== O_IDLE) begin
      miss_cnt++; $display("FAIL wrap_pre_reset obs=%b/%0d exp=%b/0", obs, retired, O_IDLE);
    end
    @(negedge clk);
    rst = 1'b1; run = 1'b1; mem_ack = 1'b1; opcode = OP_ADDI;
    repeat (61) @(negedge clk);
    vec_cnt++;
    if (retired !== 4'd15) begin
      miss_cnt++; $display("FAIL wrap_15 obs=%0d exp=15", retired);
    end
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (retired !== 4'd0 || obs !== O_F_ACK) begin
      miss_cnt++; $display("FAIL wrap_0 obs=%b/%0d exp=%b/0", obs, retired, O_F_ACK);
    end
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (retired !== 4'd1 || obs !== O_F_ACK) begin
      miss_cnt++; $display("FAIL wrap_1 obs=%b/%0d exp=%b/1", obs, retired, O_F_ACK);
    end
    opcode = OP_LOAD;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (obs !== O_MEM_RD) begin
      miss_cnt++; $display("FAIL rst_mid_mem_pre obs=%b exp=%b", obs, O_MEM_RD);
    end
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if (mem_req !== 1'b0 || stage !== 3'd0 || retired !== 4'd0) begin
      miss_cnt++;
      $display("FAIL rst_mid_mem req=%b stage=%0d retired=%0d exp 0/0/0", mem_req, stage, retired);
    end
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_IDLE) begin
      miss_cnt++; $display("FAIL rst_mid_mem_after obs=%b exp=%b", obs, O_IDLE);
    end
  endtask

  task automatic test_mem_wait();
    opcode = OP_ADDI; mem_ack = 1'b0; run = 1'b1;
`ifdef SEQ_MEM_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== O_F_WAIT) begin
        miss_cnt++; $display("FAIL tmo_wait%0d obs=%b exp=%b", i + 1, obs, O_F_WAIT);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (obs !== O_FAULT) begin
      miss_cnt++; $display("FAIL tmo_fault obs=%b exp=%b", obs, O_FAULT);
    end
    mem_ack = 1'b1;
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (obs !== O_FAULT) begin
      miss_cnt++; $display("FAIL tmo_sticky obs=%b exp=%b", obs, O_FAULT);
    end
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs !== O_F_WAIT) begin
        miss_cnt++; $display("FAIL fetch_hold%0d obs=%b exp=%b", i + 1, obs, O_F_WAIT);
      end
    end
`endif
    rst = 1'b0; run = 1'b0; mem_ack = 1'b1;
    #1;
    vec_cnt++;
    if (obs !== O_IDLE) begin
      miss_cnt++; $display("FAIL wait_reset obs=%b exp=%b", obs, O_IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_branch();
    test_stall_run();
    test_wrap_reset();
    test_mem_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
